// File: rtl/systolic_pkg.sv
// Types and width helpers shared by systolic_unary_matmul, its result drain and their benches.
package systolic_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Width of one C element: full product width plus growth from summing a_col products.
    function automatic int c_width(input int bit_width, input int a_col);
        return (bit_width << 1) + a_col;
    endfunction

    // Index width for a dimension of size n; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_result_drain.sv
// Snapshots the matmul C matrix on the rising edge of mat_done and streams it out row-major.
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int BIT_WIDTH = 3,
    parameter int A_ROW     = 2,
    parameter int A_COL     = 2,
    parameter int B_COL     = 2,
    localparam int C_WIDTH  = c_width(BIT_WIDTH, A_COL),
    localparam int NUM_EL   = A_ROW * B_COL,
    localparam int ROW_W    = idx_width(A_ROW),
    localparam int COL_W    = idx_width(B_COL)
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     mat_done,
    input  logic [A_ROW-1:0][B_COL-1:0][C_WIDTH-1:0] C,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [C_WIDTH-1:0]                       out_data,
    output logic [ROW_W-1:0]                         out_row,
    output logic [COL_W-1:0]                         out_col,
    output logic                                     out_last,
    output logic                                     busy,
    output logic                                     overrun,
    output state_t                                   state
);

    // Handshake: a beat transfers on a posedge where out_valid && out_ready; once
    // out_valid is high, out_data/out_row/out_col/out_last hold until that transfer.

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(A_ROW - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(B_COL - 1);
    localparam logic             SINGLE   = (NUM_EL == 1);

    logic [A_ROW-1:0][B_COL-1:0][C_WIDTH-1:0] c_buf;
    logic                                     done_q;
    logic                                     start;
    logic                                     hs;
    logic                                     load;
    logic [ROW_W-1:0]                         nxt_row;
    logic [COL_W-1:0]                         nxt_col;

    always_comb begin
        start = mat_done && !done_q;
        hs    = out_valid && out_ready;
        // A start coinciding with the final transfer reloads without a bubble.
        load  = start && ((state == IDLE) || (hs && out_last));
    end

    always_comb begin
        nxt_row = out_row;
        nxt_col = out_col + COL_W'(1);
        if (out_col == LAST_COL) begin
            nxt_col = '0;
            nxt_row = out_row + ROW_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            done_q    <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
        end else begin
            done_q <= mat_done;
            if (load) begin
                c_buf     <= C;
                state     <= DRAIN;
                out_valid <= 1'b1;
                busy      <= 1'b1;
                out_row   <= '0;
                out_col   <= '0;
                out_data  <= C[0][0];
                out_last  <= SINGLE;
            end else begin
                case (state)
                    IDLE: begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                    DRAIN: begin
                        if (start) begin
                            overrun <= 1'b1;
                        end
                        if (hs) begin
                            if (out_last) begin
                                state     <= IDLE;
                                out_valid <= 1'b0;
                                busy      <= 1'b0;
                                out_last  <= 1'b0;
                                out_row   <= '0;
                                out_col   <= '0;
                                out_data  <= '0;
                            end else begin
                                out_row  <= nxt_row;
                                out_col  <= nxt_col;
                                out_data <= c_buf[nxt_row][nxt_col];
                                out_last <= (nxt_row == LAST_ROW) && (nxt_col == LAST_COL);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain at default parameters (2x2 C, 8-bit elements).
module tb_systolic_result_drain;
    import systolic_pkg::*;

    localparam int BW = 3;
    localparam int AR = 2;
    localparam int AC = 2;
    localparam int BC = 2;
    localparam int CW = 8;

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         mat_done;
    logic [AR-1:0][BC-1:0][CW-1:0] c_in;
    logic                         out_valid;
    logic                         out_ready;
    logic [CW-1:0]                out_data;
    logic [0:0]                   out_row;
    logic [0:0]                   out_col;
    logic                         out_last;
    logic                         busy;
    logic                         overrun;
    state_t                       state;

    int            n_checks = 0;
    int            n_pass   = 0;
    int            k;
    logic [1:0]    kb;
    logic [CW-1:0] ed;
    logic [CW-1:0] exp_q[$];

    always #5 clk = ~clk;

    systolic_result_drain #(
        .BIT_WIDTH(BW), .A_ROW(AR), .A_COL(AC), .B_COL(BC)
    ) dut (
        .clk(clk), .reset(reset), .mat_done(mat_done), .C(c_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last),
        .busy(busy), .overrun(overrun), .state(state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_c(input logic [7:0] e00, input logic [7:0] e01,
                         input logic [7:0] e10, input logic [7:0] e11);
        c_in[0][0] = e00;
        c_in[0][1] = e01;
        c_in[1][0] = e10;
        c_in[1][1] = e11;
    endtask

    task automatic test_reset();
        reset = 1'b1; mat_done = 1'b0; out_ready = 1'b0; c_in = '0;
        tick();
        n_checks++;
        if ({out_valid, busy, overrun, out_last} !== 4'b0000)
            $display("FAIL reset_flags: got %b exp 0000", {out_valid, busy, overrun, out_last});
        else n_pass++;
        n_checks++;
        if ({out_data, out_row, out_col} !== 10'd0)
            $display("FAIL reset_data: got %h exp 000", {out_data, out_row, out_col});
        else n_pass++;
        n_checks++;
        if (state !== IDLE) $display("FAIL reset_state: got %0d exp IDLE", state);
        else n_pass++;
        reset = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL idle_quiet: out_valid %b exp 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_basic();
        int busy_cnt;
        busy_cnt = 0; k = 0;
        set_c(8'd20, 8'd63, 8'd5, 8'd35);
        exp_q = '{8'd20, 8'd63, 8'd5, 8'd35};
        out_ready = 1'b1; mat_done = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            mat_done = 1'b0;
            if (i == 0) begin
                n_checks++;
                if (out_valid !== 1'b1) $display("FAIL basic_latency: out_valid %b exp 1", out_valid);
                else n_pass++;
            end
            if (busy) busy_cnt++;
            if (out_valid && out_ready) begin
                kb = k[1:0];
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL basic_extra: data %0d exp none", out_data);
                else begin
                    ed = exp_q.pop_front();
                    if ({out_data, out_row, out_col, out_last} !== {ed, kb[1], kb[0], kb == 2'd3})
                        $display("FAIL basic_beat%0d: got %0d (%0d,%0d) last %b exp %0d (%0d,%0d) last %b",
                                 k, out_data, out_row, out_col, out_last, ed, kb[1], kb[0], kb == 2'd3);
                    else n_pass++;
                end
                k++;
            end
        end
        n_checks++;
        if (k !== 4) $display("FAIL basic_count: got %0d exp 4", k); else n_pass++;
        n_checks++;
        if (busy_cnt !== 4) $display("FAIL basic_busy: got %0d exp 4", busy_cnt); else n_pass++;
        n_checks++;
        if (overrun !== 1'b0) $display("FAIL basic_overrun: got %b exp 0", overrun); else n_pass++;
    endtask

    task automatic test_stall();
        int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
        logic          stalled;
        logic [CW+2:0] snap;
        stalled = 1'b0; snap = '0; k = 0;
        set_c(8'd20, 8'd63, 8'd5, 8'd35);
        exp_q = '{8'd20, 8'd63, 8'd5, 8'd35};
        out_ready = 1'b0; mat_done = 1'b1;
        tick();
        mat_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (stalled) begin
                n_checks++;
                if ({out_valid, out_data, out_row, out_col} !== snap)
                    $display("FAIL stall_hold%0d: got %h exp %h", i, {out_valid, out_data, out_row, out_col}, snap);
                else n_pass++;
            end
            out_ready = (i < 7) ? pat[i][0] : 1'b1;
            if (out_valid && out_ready) begin
                kb = k[1:0];
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL stall_extra: data %0d exp none", out_data);
                else begin
                    ed = exp_q.pop_front();
                    if ({out_data, out_row, out_col, out_last} !== {ed, kb[1], kb[0], kb == 2'd3})
                        $display("FAIL stall_beat%0d: got %0d (%0d,%0d) last %b exp %0d",
                                 k, out_data, out_row, out_col, out_last, ed);
                    else n_pass++;
                end
                k++;
            end
            stalled = out_valid && !out_ready;
            snap = {out_valid, out_data, out_row, out_col};
            tick();
        end
        n_checks++;
        if (k !== 4) $display("FAIL stall_count: got %0d exp 4", k); else n_pass++;
    endtask

    task automatic test_hold();
        k = 0;
        set_c(8'd20, 8'd63, 8'd5, 8'd35);
        exp_q = '{8'd20, 8'd63, 8'd5, 8'd35};
        out_ready = 1'b1; mat_done = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i == 9) mat_done = 1'b0;
            if (out_valid && out_ready) begin
                kb = k[1:0];
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL hold_recapture: data %0d exp none", out_data);
                else begin
                    ed = exp_q.pop_front();
                    if ({out_data, out_row, out_col, out_last} !== {ed, kb[1], kb[0], kb == 2'd3})
                        $display("FAIL hold_beat%0d: got %0d exp %0d", k, out_data, ed);
                    else n_pass++;
                end
                k++;
            end
        end
        n_checks++;
        if (k !== 4) $display("FAIL hold_count: got %0d exp 4", k); else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL hold_idle: busy %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_overrun();
        k = 0;
        set_c(8'd20, 8'd63, 8'd5, 8'd35);
        exp_q = '{8'd20, 8'd63, 8'd5, 8'd35};
        out_ready = 1'b1; mat_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 1) begin
                mat_done = 1'b1; set_c(8'd1, 8'd2, 8'd3, 8'd4); out_ready = 1'b0;
            end else begin
                mat_done = 1'b0; out_ready = 1'b1;
            end
            if (i == 2) begin
                n_checks++;
                if (overrun !== 1'b1) $display("FAIL overrun_set: got %b exp 1", overrun); else n_pass++;
                n_checks++;
                if (out_data !== 8'd63) $display("FAIL overrun_hold: got %0d exp 63", out_data); else n_pass++;
            end
            if (out_valid && out_ready) begin
                kb = k[1:0];
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL overrun_extra: data %0d exp none", out_data);
                else begin
                    ed = exp_q.pop_front();
                    if ({out_data, out_row, out_col, out_last} !== {ed, kb[1], kb[0], kb == 2'd3})
                        $display("FAIL overrun_beat%0d: got %0d exp %0d", k, out_data, ed);
                    else n_pass++;
                end
                k++;
            end
        end
        n_checks++;
        if (k !== 4) $display("FAIL overrun_count: got %0d exp 4", k); else n_pass++;
        n_checks++;
        if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %b exp 1", overrun); else n_pass++;
    endtask

    task automatic test_reset_mid();
        set_c(8'd20, 8'd63, 8'd5, 8'd35);
        out_ready = 1'b1; mat_done = 1'b1;
        tick();
        mat_done = 1'b0;
        n_checks++;
        if ({out_valid, out_data, out_row, out_col} !== {1'b1, 8'd20, 1'b0, 1'b0})
            $display("FAIL mid_first: got %h exp 1_14_0_0", {out_valid, out_data, out_row, out_col});
        else n_pass++;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({out_valid, busy, overrun} !== 3'b000)
            $display("FAIL mid_reset_flags: got %b exp 000", {out_valid, busy, overrun});
        else n_pass++;
        n_checks++;
        if (state !== IDLE) $display("FAIL mid_reset_state: got %0d exp IDLE", state); else n_pass++;
        k = 0;
        set_c(8'd255, 8'd128, 8'd0, 8'd170);
        exp_q = '{8'd255, 8'd128, 8'd0, 8'd170};
        mat_done = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            mat_done = 1'b0;
            if (out_valid && out_ready) begin
                kb = k[1:0];
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL restart_extra: data %0d exp none", out_data);
                else begin
                    ed = exp_q.pop_front();
                    if ({out_data, out_row, out_col, out_last} !== {ed, kb[1], kb[0], kb == 2'd3})
                        $display("FAIL restart_beat%0d: got %0d (%0d,%0d) exp %0d", k, out_data, out_row, out_col, ed);
                    else n_pass++;
                end
                k++;
            end
        end
        n_checks++;
        if (k !== 4) $display("FAIL restart_count: got %0d exp 4", k); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int gap;
        gap = 0; k = 0;
        set_c(8'd20, 8'd63, 8'd5, 8'd35);
        exp_q = '{8'd20, 8'd63, 8'd5, 8'd35, 8'd1, 8'd2, 8'd3, 8'd4};
        out_ready = 1'b1; mat_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            mat_done = 1'b0;
            if (i == 3) begin
                mat_done = 1'b1; set_c(8'd1, 8'd2, 8'd3, 8'd4);
            end
            if (i < 8 && !out_valid) gap++;
            if (out_valid && out_ready) begin
                kb = k[1:0];
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL b2b_extra: data %0d exp none", out_data);
                else begin
                    ed = exp_q.pop_front();
                    if ({out_data, out_row, out_col, out_last} !== {ed, kb[1], kb[0], kb == 2'd3})
                        $display("FAIL b2b_beat%0d: got %0d (%0d,%0d) last %b exp %0d",
                                 k, out_data, out_row, out_col, out_last, ed);
                    else n_pass++;
                end
                k++;
            end
        end
        n_checks++;
        if (k !== 8) $display("FAIL b2b_count: got %0d exp 8", k); else n_pass++;
        n_checks++;
        if (gap !== 0) $display("FAIL b2b_gap: got %0d idle cycles exp 0", gap); else n_pass++;
        n_checks++;
        if (overrun !== 1'b0) $display("FAIL b2b_overrun: got %b exp 0", overrun); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_hold();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Sits directly downstream of systolic_unary_matmul.
- When the matmul raises its completion level, this block snapshots the full C result matrix into a local buffer.
- It then streams the elements out one per handshake, row-major, on a valid/ready interface toward binary post-processing or writeback.
- It decouples the matmul from a slow consumer and flags any result lost because the drain was still busy.

Parameters:
- BIT_WIDTH, 3, operand width fed to the matmul.
- A_ROW, 2, rows of C.
- A_COL, 2, inner dimension; sets accumulator growth.
- B_COL, 2, columns of C.
- C_WIDTH (localparam), (BIT_WIDTH<<1)+A_COL, width of one C element (8 at defaults).
- NUM_EL (localparam), A_ROW*B_COL, total element count.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-high reset.
- mat_done  in  1  matmul output_ready level; a result is available while high.
- C  in  [A_ROW-1:0][B_COL-1:0][C_WIDTH-1:0]  matmul result matrix, valid while mat_done is high.
- out_valid  out  1  out_data holds a valid element.
- out_ready  in  1  consumer accepts the element when out_valid && out_ready.
- out_data  out  C_WIDTH  current element.
- out_row  out  $clog2(A_ROW) (min 1)  row index of out_data.
- out_col  out  $clog2(B_COL) (min 1)  column index of out_data.
- out_last  out  1  high with the final element (row A_ROW-1, col B_COL-1).
- busy  out  1  high in DRAIN.
- overrun  out  1  sticky; a result arrived while draining and was dropped.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. Reset takes priority over all other events.
  - State goes to IDLE.
  - out_valid, out_last, busy and overrun go to 0; out_data, out_row and out_col go to 0.
  - done_q (registered mat_done) goes to 0.
  - Buffer contents are don't-care.
- Start event: start = mat_done && !done_q. This is a rising edge, so a level held high produces exactly one capture. If mat_done is already high in the first cycle after reset, that counts as a start.
- IDLE:
  - On start, latch the entire C array into the buffer and set index row=0, col=0.
  - The next cycle is DRAIN with out_valid=1. Latency is one cycle from the start edge to the first out_valid.
- DRAIN:
  - out_valid=1 and busy=1. out_data = buffer[row][col].
  - out_last = (row==A_ROW-1 && col==B_COL-1).
  - Handshake: col increments; when col==B_COL-1 it wraps to 0 and row increments.
  - Handshake with out_last high returns the block to IDLE: out_valid=0, busy=0, indices=0.
  - With out_ready low, out_data, out_row, out_col and out_last hold stable. out_valid never drops without a handshake.
- Boundaries:
  - Start in DRAIN, without a final handshake that cycle: the result is dropped and overrun is set. The buffer is untouched and draining continues.
  - Start in the same cycle as the final handshake: the new C is captured, indices reset to 0, and the block stays in DRAIN. This gives back-to-back drains with no bubble, and overrun is not set.
  - overrun clears only on reset.
  - Elements are passed through unmodified: no truncation or sign extension. C is unsigned.
  - With A_ROW=1 or B_COL=1, the index width is 1 and that index stays 0.

Decomposition:
- Shared package systolic_pkg:
  - C_WIDTH computation as a function of BIT_WIDTH and A_COL, shared with the matmul and its bench.
  - State enum typedef {IDLE, DRAIN}.
- No sub-module. A single module holds the FSM, index counters and buffer. The rising-edge detector is a single flop inline.

Test Plan:
- Defaults; A=[[6,7],[5,0]], B=[[1,7],[2,3]] through the matmul, out_ready held 1.
  -> Four beats, one per cycle: 20,63,5,35 at (0,0),(0,1),(1,0),(1,1).
  -> out_last only on 35. busy is high for exactly 4 cycles; overrun=0.
- Same result, out_ready toggling 1,0,0,1,0,1,1.
  -> out_data and indices are stable during the low cycles.
  -> Exactly 4 handshakes, values 20,63,5,35; no duplicates.
- mat_done held high for 10 cycles after a single result.
  -> Exactly one drain of 4 beats; no re-capture.
- Second mat_done rising edge while the drain is at beat 2 with out_ready=0.
  -> overrun=1 and stays 1. Remaining beats still carry the first result; the second result is never emitted.
- Second rising edge, carrying C=[[1,2],[3,4]], in the same cycle as the handshake of 35.
  -> The next cycle begins 1,2,3,4 with no gap; overrun stays 0.
- reset asserted mid-drain, after beat 1.
  -> The next cycle has out_valid=0, busy=0, overrun=0 and IDLE.
  -> A fresh mat_done edge then restarts from (0,0).
